// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states
// and the HI/LO reset value.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_t;

  // Every bit of HI and LO resets to this value.
  localparam logic HILO_RST_BIT = 1'b0;

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational conditional two's-complement negate.
// Used for operand magnitudes at accept and for result sign correction.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative shift-add multiply / restoring divide owning HI and LO.
// Define MDU_DIV_EN to build the divide datapath; otherwise div/divu starts are ignored.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t         state;
  logic [CW-1:0]      cnt;
  logic               neg_q;
  logic [WIDTH-1:0]   opb;
  // Multiply: {upper accumulator, multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] prod;

  logic               signed_op;
  logic               accept_ok;
  logic               accept;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH:0]   mul_pre;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign busy      = (state != ST_IDLE);
  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign accept    = (state == ST_IDLE) && start && accept_ok;

  mdu_sign_fix #(.W(WIDTH)) u_rs_abs (
    .neg(signed_op & rs_val[WIDTH-1]), .a(rs_val), .y(rs_abs));
  mdu_sign_fix #(.W(WIDTH)) u_rt_abs (
    .neg(signed_op & rt_val[WIDTH-1]), .a(rt_val), .y(rt_abs));
  mdu_sign_fix #(.W(2*WIDTH)) u_prod_fix (
    .neg(neg_q), .a(prod), .y(prod_fix));

  assign add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, opb};
  assign mul_pre  = prod[0] ? {add_sum, prod[WIDTH-1:0]} : {1'b0, prod};
  assign mul_next = mul_pre[2*WIDTH:1];

`ifdef MDU_DIV_EN
  logic [1:0]       op_q;
  logic             rneg_q;
  logic             dz_q;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign accept_ok = 1'b1;
  assign r_sh      = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
  assign diff      = {1'b0, r_sh} - {2'b00, opb};
  // A borrow out of the trial subtract means restore and shift in a 0.
  assign div_next  = diff[WIDTH+1] ? {r_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                   : {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
  assign step_next = op_q[1] ? div_next : mul_next;

  mdu_sign_fix #(.W(WIDTH)) u_quo_fix (
    .neg(neg_q), .a(prod[WIDTH-1:0]), .y(quo_fix));
  mdu_sign_fix #(.W(WIDTH)) u_rem_fix (
    .neg(rneg_q), .a(prod[2*WIDTH-1:WIDTH]), .y(rem_fix));

  // Divide by zero leaves the dividend in the remainder naturally; only LO needs forcing.
  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (op_q[1]) begin
      fix_hi = rem_fix;
      fix_lo = dz_q ? {WIDTH{1'b1}} : quo_fix;
    end
  end
`else
  assign accept_ok = ~op[1];
  assign step_next = mul_next;

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= {WIDTH{HILO_RST_BIT}};
      lo    <= {WIDTH{HILO_RST_BIT}};
      done  <= 1'b0;
      neg_q <= 1'b0;
      opb   <= '0;
      prod  <= '0;
`ifdef MDU_DIV_EN
      op_q   <= MDU_MULT;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            prod  <= {{WIDTH{1'b0}}, rs_abs};
            opb   <= rt_abs;
            neg_q <= signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            cnt   <= CW'(WIDTH - 1);
            state <= ST_RUN;
`ifdef MDU_DIV_EN
            op_q   <= op;
            rneg_q <= signed_op & rs_val[WIDTH-1];
            dz_q   <= (rt_val == '0);
`endif
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        ST_RUN: begin
          prod <= step_next;
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - CW'(1);
        end
        ST_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed vector table, multi-cycle corner sequences
// and random ops against an arithmetic reference model.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int W = 32;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] rs_val, rt_val, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_hi, m_lo;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;
  vec_t vecs[7];

  mdu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    h = '0;
    l = '0;
    case (o)
      MDU_MULT:  begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      MDU_MULTU: begin p = ua * ub;      h = p[63:32]; l = p[31:0]; end
      MDU_DIV: begin
        if (b == 0) begin h = a; l = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = '0; l = 32'h8000_0000; end
        else begin q = sa / sb; r = sa % sb; h = 32'(r); l = 32'(q); end
      end
      default: begin
        if (b == 0) begin h = a; l = '1; end
        else begin h = 32'(ua % ub); l = 32'(ua / ub); end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Issues one accepted op, checks busy length and the done pulse, then pops
  // the expected HI/LO pair. inj >= 0 injects start+mthi at that RUN cycle.
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int inj, input bit with_mthi);
    int bcnt;
    int dbad;
    logic [W-1:0] eh, el;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    mthi = with_mthi; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    bcnt = 0;
    dbad = 0;
    while (busy && bcnt < 100) begin
      if (done) dbad++;
      if (bcnt == inj) begin
        start = 1'b1; op = MDU_MULTU; rs_val = W'($urandom); rt_val = W'($urandom);
        mthi = 1'b1; wdata = 32'h1234;
      end
      bcnt++;
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0;
    end
    check($sformatf("%s busy_cycles", name), W'(bcnt), W'(W + 1));
    check($sformatf("%s done_during_busy", name), W'(dbad), '0);
    check($sformatf("%s done_pulse", name), W'(done), W'(1));
    eh = exp_q.pop_front();
    el = exp_q.pop_front();
    check($sformatf("%s hi", name), hi, eh);
    check($sformatf("%s lo", name), lo, el);
    @(posedge clk); #1;
    check($sformatf("%s done_single", name), W'(done), '0);
    m_hi = eh;
    m_lo = el;
  endtask

  // A start that must not be accepted (divide with the divider compiled out).
  task automatic run_ignored(input string name, input logic [1:0] o, input logic [W-1:0] a,
                             input logic [W-1:0] b);
    int seen;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("%s busy", name), W'(busy), '0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (done || busy) seen++;
      @(posedge clk); #1;
    end
    check($sformatf("%s no_activity", name), W'(seen), '0);
    check($sformatf("%s hi", name), hi, m_hi);
    check($sformatf("%s lo", name), lo, m_lo);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [W-1:0] eh, el, a, b;
    logic [1:0]   o;
    int           seen;

    vecs[0] = '{MDU_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{MDU_DIVU,  32'd100,        32'd7,         32'd2,         32'd14};
    vecs[4] = '{MDU_DIV,   32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[5] = '{MDU_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[6] = '{MDU_MULT,  32'd3,          32'd4,         32'd0,         32'd12};

    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = MDU_MULT; rs_val = '0; rt_val = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    check("reset hi", hi, '0);
    check("reset lo", lo, '0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;

    // Second start and mthi during RUN are ignored.
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd21);
    run_op("ignore_in_run", MDU_MULT, 32'd7, 32'd3, 5, 1'b0);

    // mthi in the same cycle as an accepted start is dropped.
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd6);
    run_op("start_beats_mthi", MDU_MULTU, 32'd2, 32'd3, -1, 1'b1);

    // Reset at RUN cycle 10 aborts with no result.
    @(negedge clk);
    start = 1'b1; op = MDU_MULTU; rs_val = 32'hFFFF_FFFF; rt_val = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort busy_before", W'(busy), W'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", W'(busy), '0);
    check("abort hi", hi, '0);
    check("abort lo", lo, '0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) seen++;
      @(posedge clk); #1;
    end
    check("abort no_done", W'(seen), '0);
    m_hi = '0;
    m_lo = '0;

    // mtlo alone, then mthi+mtlo together, in IDLE.
    @(negedge clk);
    mtlo = 1'b1; wdata = 32'hABCD;
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("mtlo lo", lo, 32'hABCD);
    check("mtlo hi", hi, '0);
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_0F0F;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo hi", hi, 32'h5A5A_0F0F);
    check("mthi_mtlo lo", lo, 32'h5A5A_0F0F);
    m_hi = 32'h5A5A_0F0F;
    m_lo = 32'h5A5A_0F0F;

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].op[1] && !DIV_EN) begin
        run_ignored($sformatf("vec%0d_ignored", i), vecs[i].op, vecs[i].a, vecs[i].b);
      end else begin
        exp_q.push_back(vecs[i].hi);
        exp_q.push_back(vecs[i].lo);
        run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, -1, 1'b0);
      end
    end

    // Random ops against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      o = DIV_EN ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
      a = pick();
      b = pick();
      model(o, a, b, eh, el);
      exp_q.push_back(eh);
      exp_q.push_back(el);
      run_op($sformatf("rnd%0d op%0d %h %h", i, o, a, b), o, a, b, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
